// File: rtl/sti_dac_gen.sv
// Serial frame transmitter: builds 8..2*DATA_W bit frames, shifts them out, packs
// the stream into pixels and scatters them checkerboard-wise over odd/even banks.
module sti_dac_gen #(
    parameter int DATA_W        = 16,
    parameter int LEN_W         = $clog2(2*DATA_W/8),
    parameter int IMG_W         = 16,
    parameter int ROWS_PER_BANK = 4,
    parameter int NBANK         = 4,
    parameter int ADDR_W        = $clog2(ROWS_PER_BANK*IMG_W/2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic              ready,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic [ADDR_W-1:0] oem_addr,
    output logic [7:0]        oem_dataout,
    output logic [NBANK-1:0]  odd_wr,
    output logic [NBANK-1:0]  even_wr,
    output logic              oem_finish
);

    localparam int TOTAL = IMG_W*ROWS_PER_BANK*NBANK;
    localparam int FW    = 2*DATA_W;
    localparam int CNT_W = LEN_W + 4;
    localparam int PW    = $clog2(TOTAL+1);

    localparam logic [LEN_W:0]   MAX_BYTES = (LEN_W+1)'(FW/8);
    localparam logic [CNT_W-1:0] DW_C      = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] FW_C      = CNT_W'(FW);
    localparam logic [PW-1:0]    TOTAL_C   = PW'(TOTAL);

    typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;

    state_t            state;
    logic [FW-1:0]     sreg;
    logic [CNT_W-1:0]  f_len;
    logic [CNT_W-1:0]  bit_cnt;
    logic              msb_first;
    logic              end_flag;
    logic [7:0]        pix_sh;
    logic [2:0]        pix_cnt;
    logic [PW-1:0]     pix_idx;

    logic [LEN_W:0]    n_bytes;
    logic [CNT_W-1:0]  f_new;
    logic [FW-1:0]     frame_new;
    logic [FW-1:0]     sreg_new;

    // Frame is pre-aligned so the next bit to send always sits at one end of sreg.
    always_comb begin
        n_bytes = {1'b0, pi_length} + (LEN_W+1)'(1);
        if (n_bytes > MAX_BYTES)
            n_bytes = MAX_BYTES;
        f_new = {n_bytes, 3'b000};
        if (f_new <= DW_C) begin
            if (pi_low)
                frame_new = {{DATA_W{1'b0}}, pi_data & ({DATA_W{1'b1}} >> (DW_C - f_new))};
            else
                frame_new = {{DATA_W{1'b0}}, pi_data >> (DW_C - f_new)};
        end else if (pi_fill) begin
            frame_new = {{DATA_W{1'b0}}, pi_data} << (f_new - DW_C);
        end else begin
            frame_new = {{DATA_W{1'b0}}, pi_data};
        end
        sreg_new = pi_msb ? (frame_new << (FW_C - f_new)) : frame_new;
    end

    int unsigned       map_row;
    int unsigned       map_col;
    logic              map_odd;
    logic [ADDR_W-1:0] map_addr;
    logic [NBANK-1:0]  map_bank;

    always_comb begin
        map_row  = 32'(pix_idx) / IMG_W;
        map_col  = 32'(pix_idx) % IMG_W;
        map_odd  = map_row[0] ^ map_col[0];
        map_addr = ADDR_W'((map_row % ROWS_PER_BANK) * (IMG_W/2) + map_col / 2);
        map_bank = NBANK'(1) << (map_row / ROWS_PER_BANK);
    end

    logic [7:0]    byte_val;
    logic          do_write;
    logic [PW-1:0] pix_next;

    assign byte_val = {pix_sh[6:0], so_data};
    assign do_write = so_valid && (pix_cnt == 3'd7) && (pix_idx < TOTAL_C);
    assign pix_next = pix_idx + PW'(do_write);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sreg        <= '0;
            f_len       <= '0;
            bit_cnt     <= '0;
            msb_first   <= 1'b0;
            end_flag    <= 1'b0;
            pix_sh      <= '0;
            pix_cnt     <= '0;
            pix_idx     <= '0;
            ready       <= 1'b1;
            so_data     <= 1'b0;
            so_valid    <= 1'b0;
            oem_addr    <= '0;
            oem_dataout <= '0;
            odd_wr      <= '0;
            even_wr     <= '0;
            oem_finish  <= 1'b0;
        end else begin
            odd_wr  <= '0;
            even_wr <= '0;

            // Packing taps the registered serial output, so each pulse trails its 8th bit.
            if (so_valid) begin
                pix_sh  <= byte_val;
                pix_cnt <= pix_cnt + 3'd1;
            end
            if (do_write) begin
                oem_addr    <= map_addr;
                oem_dataout <= byte_val;
                if (map_odd) odd_wr  <= map_bank;
                else         even_wr <= map_bank;
                pix_idx     <= pix_next;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        so_valid  <= 1'b1;
                        so_data   <= pi_msb ? sreg_new[FW-1] : sreg_new[0];
                        sreg      <= pi_msb ? (sreg_new << 1) : (sreg_new >> 1);
                        bit_cnt   <= CNT_W'(1);
                        f_len     <= f_new;
                        msb_first <= pi_msb;
                        end_flag  <= pi_end;
                        ready     <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == f_len) begin
                        so_valid <= 1'b0;
                        so_data  <= 1'b0;
                        if (end_flag) begin
                            state <= (pix_next == TOTAL_C) ? DONE : FILL;
                        end else begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        so_data <= msb_first ? sreg[FW-1] : sreg[0];
                        sreg    <= msb_first ? (sreg << 1) : (sreg >> 1);
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (pix_idx < TOTAL_C) begin
                        oem_addr    <= map_addr;
                        oem_dataout <= 8'h00;
                        if (map_odd) odd_wr  <= map_bank;
                        else         even_wr <= map_bank;
                        pix_idx     <= pix_idx + PW'(1);
                        if (pix_idx == TOTAL_C - PW'(1))
                            state <= DONE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    oem_finish <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sti_dac_gen.sv
// Testbench for sti_dac_gen: vector table plus scoreboard queues of expected
// serial bits and bank writes, with hand-written reset, overflow and fill sequences.
module tb_sti_dac_gen;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 2;
    localparam int IMG_W  = 16;
    localparam int RPB    = 4;
    localparam int NBANK  = 4;
    localparam int ADDR_W = 5;
    localparam int TOTAL  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] pi_data = '0;
    logic [LEN_W-1:0]  pi_length = '0;
    logic              pi_fill = 1'b0;
    logic              pi_msb = 1'b0;
    logic              pi_low = 1'b0;
    logic              pi_end = 1'b0;
    logic              so_data;
    logic              so_valid;
    logic [ADDR_W-1:0] oem_addr;
    logic [7:0]        oem_dataout;
    logic [NBANK-1:0]  odd_wr;
    logic [NBANK-1:0]  even_wr;
    logic              oem_finish;

    sti_dac_gen #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .IMG_W(IMG_W),
        .ROWS_PER_BANK(RPB), .NBANK(NBANK), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .ready(ready),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid), .oem_addr(oem_addr),
        .oem_dataout(oem_dataout), .odd_wr(odd_wr), .even_wr(even_wr),
        .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  len;
        logic        fill;
        logic        msb;
        logic        low;
        logic [15:0] data;
        int          f;
        logic [31:0] frame;
    } vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic       odd;
        logic [3:0] bank;
    } wr_t;

    logic bitq[$];
    wr_t  wrq[$];
    int   total = 0;
    int   bad = 0;
    int   model_p = 0;
    bit   mon_en = 1'b0;
    int   wr_seen = 0;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [3:0] last_odd = '0;
    logic [3:0] last_even = '0;
    logic mon_b;
    wr_t  mon_w;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushPixel(input logic [7:0] d);
        wr_t w;
        int row, col;
        if (model_p < TOTAL) begin
            row    = model_p / IMG_W;
            col    = model_p % IMG_W;
            w.addr = 5'((row % RPB) * (IMG_W/2) + col / 2);
            w.data = d;
            w.odd  = ((row + col) % 2) == 1;
            w.bank = 4'(1 << (row / RPB));
            wrq.push_back(w);
            model_p++;
        end
    endtask

    task automatic pushFrame(input int f, input logic [31:0] frame, input logic msb);
        logic [7:0] px;
        logic b;
        px = '0;
        for (int i = 0; i < f; i++) begin
            b = msb ? frame[f-1-i] : frame[i];
            bitq.push_back(b);
            px = {px[6:0], b};
            if (i % 8 == 7)
                pushPixel(px);
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready)
            checkOutput("ready_timeout", 32'(ready), 1);
    endtask

    task automatic applyStimulus(input vec_t v, input logic endf);
        waitReady();
        pi_data   = v.data;
        pi_length = v.len;
        pi_fill   = v.fill;
        pi_msb    = v.msb;
        pi_low    = v.low;
        pi_end    = endf;
        load      = 1'b1;
        pushFrame(v.f, v.frame, v.msb);
        @(negedge clk);
        load   = 1'b0;
        pi_end = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((bitq.size() != 0 || wrq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_bits", bitq.size(), 0);
        checkOutput("drain_writes", wrq.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 reset = 1'b0;
        bitq.delete();
        wrq.delete();
        model_p = 0;
        #1;
        checkOutput("rst_valid", 32'(so_valid), 0);
        checkOutput("rst_wr", 32'({odd_wr, even_wr}), 0);
        checkOutput("rst_finish", 32'(oem_finish), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(ready), 1);
    endtask

    // Scoreboard monitor: every serial bit and bank write must match the next queued entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (so_valid) begin
                if (bitq.size() == 0) begin
                    checkOutput("extra_bit", 32'(so_valid), 0);
                end else begin
                    mon_b = bitq.pop_front();
                    checkOutput("so_data", 32'(so_data), 32'(mon_b));
                end
            end
            if ({odd_wr, even_wr} != '0) begin
                wr_seen++;
                last_addr = oem_addr;
                last_data = oem_dataout;
                last_odd  = odd_wr;
                last_even = even_wr;
                checkOutput("wr_onehot", $countones({odd_wr, even_wr}), 1);
                if (wrq.size() == 0) begin
                    checkOutput("extra_write", 32'({odd_wr, even_wr}), 0);
                end else begin
                    mon_w = wrq.pop_front();
                    checkOutput("wr_addr", 32'(oem_addr), 32'(mon_w.addr));
                    checkOutput("wr_data", 32'(oem_dataout), 32'(mon_w.data));
                    checkOutput("wr_odd", 32'(odd_wr), mon_w.odd ? 32'(mon_w.bank) : 0);
                    checkOutput("wr_even", 32'(even_wr), mon_w.odd ? 0 : 32'(mon_w.bank));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[8];
    vec_t v;
    int   seen;
    int   gaps;
    int   n;
    int   bidx;
    int   bad_cov;
    int   hits[2][NBANK][32];

    initial begin
        vecs[0] = '{2'd0, 1'b0, 1'b1, 1'b1, 16'hA53C, 8,  32'h0000003C};
        vecs[1] = '{2'd3, 1'b1, 1'b0, 1'b0, 16'h8001, 32, 32'h80010000};
        vecs[2] = '{2'd0, 1'b0, 1'b0, 1'b0, 16'hA53C, 8,  32'h000000A5};
        vecs[3] = '{2'd1, 1'b0, 1'b1, 1'b1, 16'h1234, 16, 32'h00001234};
        vecs[4] = '{2'd1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16, 32'h0000BEEF};
        vecs[5] = '{2'd2, 1'b0, 1'b1, 1'b0, 16'hC3A5, 24, 32'h0000C3A5};
        vecs[6] = '{2'd2, 1'b1, 1'b0, 1'b1, 16'h5A0F, 24, 32'h005A0F00};
        vecs[7] = '{2'd0, 1'b0, 1'b1, 1'b1, 16'h005A, 8,  32'h0000005A};

        // Power-on reset
        #1 reset = 1'b0;
        #2;
        checkOutput("init_valid", 32'(so_valid), 0);
        checkOutput("init_wr", 32'({odd_wr, even_wr}), 0);
        checkOutput("init_finish", 32'(oem_finish), 0);
        checkOutput("init_addr", 32'(oem_addr), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("init_ready", 32'(ready), 1);
        mon_en = 1'b1;

        // Table vectors: pixels 0..16
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b0);
            if (i == 0) begin
                waitDrain();
                checkOutput("t1_even", 32'(last_even), 32'h1);
                checkOutput("t1_addr", 32'(last_addr), 0);
                checkOutput("t1_data", 32'(last_data), 32'h3C);
            end
        end
        waitDrain();
        checkOutput("row1_odd", 32'(last_odd), 32'h1);
        checkOutput("row1_even", 32'(last_even), 0);
        checkOutput("row1_addr", 32'(last_addr), 8);
        checkOutput("row1_data", 32'(last_data), 32'h5A);

        // Load pulsed during SHIFT must be ignored
        waitReady();
        pi_data = 16'h1234; pi_length = 2'd1; pi_msb = 1'b1; pi_low = 1'b1; pi_fill = 1'b0;
        load = 1'b1;
        pushFrame(16, 32'h00001234, 1'b1);
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            checkOutput("shift_valid", 32'(so_valid), 1);
            checkOutput("shift_ready", 32'(ready), 0);
            if (k == 4) begin
                pi_data = 16'hFFFF;
                pi_msb  = 1'b0;
                load    = 1'b1;
            end
            if (k == 6)
                load = 1'b0;
            @(negedge clk);
        end
        checkOutput("post_valid", 32'(so_valid), 0);
        checkOutput("ready_return", 32'(ready), 1);
        waitDrain();

        // Reset in the middle of a frame
        v = '{2'd3, 1'b0, 1'b1, 1'b0, 16'h9696, 32, 32'h00009696};
        applyStimulus(v, 1'b0);
        repeat (4) @(negedge clk);
        doReset();
        v = '{2'd0, 1'b0, 1'b1, 1'b1, 16'h00C3, 8, 32'h000000C3};
        applyStimulus(v, 1'b0);
        waitDrain();
        checkOutput("rst_next_even", 32'(last_even), 32'h1);
        checkOutput("rst_next_addr", 32'(last_addr), 0);
        checkOutput("rst_next_data", 32'(last_data), 32'hC3);

        // Overflow: 64 full frames fill the image, the 65th writes nothing
        doReset();
        seen = wr_seen;
        for (int i = 0; i < 64; i++) begin
            v.len = 2'd3; v.fill = 1'b0; v.msb = 1'b1; v.low = 1'b0;
            v.data = 16'($urandom);
            v.f = 32;
            v.frame = {16'h0000, v.data};
            applyStimulus(v, 1'b0);
        end
        waitDrain();
        checkOutput("full_writes", wr_seen - seen, TOTAL);
        seen = wr_seen;
        v = '{2'd3, 1'b0, 1'b1, 1'b0, 16'hFFFF, 32, 32'h0000FFFF};
        applyStimulus(v, 1'b0);
        waitDrain();
        checkOutput("overflow_writes", wr_seen - seen, 0);
        checkOutput("overflow_finish", 32'(oem_finish), 0);
        checkOutput("overflow_ready", 32'(ready), 1);

        // End frame followed by zero fill
        doReset();
        for (int o = 0; o < 2; o++)
            for (int b = 0; b < NBANK; b++)
                for (int a = 0; a < 32; a++)
                    hits[o][b][a] = 0;
        v = '{2'd0, 1'b0, 1'b0, 1'b1, 16'h00A7, 8, 32'h000000A7};
        applyStimulus(v, 1'b1);
        for (int p = 1; p < TOTAL; p++)
            pushPixel(8'h00);
        n = 0;
        while ({odd_wr, even_wr} == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_write", 32'(|{odd_wr, even_wr}), 1);
        gaps = 0;
        for (int c = 0; c < TOTAL; c++) begin
            if ({odd_wr, even_wr} == '0) begin
                gaps++;
            end else begin
                bidx = 0;
                for (int b = 0; b < NBANK; b++)
                    if (odd_wr[b] || even_wr[b]) bidx = b;
                hits[(|odd_wr) ? 1 : 0][bidx][oem_addr]++;
            end
            if (c == TOTAL - 1)
                checkOutput("finish_before_last", 32'(oem_finish), 0);
            @(negedge clk);
        end
        checkOutput("finish_rise", 32'(oem_finish), 1);
        checkOutput("wr_after_fill", 32'({odd_wr, even_wr}), 0);
        checkOutput("fill_gaps", gaps, 0);
        bad_cov = 0;
        for (int o = 0; o < 2; o++)
            for (int b = 0; b < NBANK; b++)
                for (int a = 0; a < 32; a++)
                    if (hits[o][b][a] != 1) bad_cov++;
        checkOutput("addr_cover", bad_cov, 0);

        // DONE holds and ignores load
        load = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("done_valid", 32'(so_valid), 0);
            checkOutput("done_ready", 32'(ready), 0);
        end
        load = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("finish_hold", 32'(oem_finish), 1);
        waitDrain();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sti_dac_gen.md
# sti_dac_gen

Parametrised serial-transmitter/data-arrangement controller. It accepts parallel words over a ready/load handshake and builds a frame from each one, 8 to 2*DATA_W bits wide, with fill, alignment and bit-order modes. It shifts the frame out serially and packs the serial stream into 8-bit pixels. The pixels are distributed checkerboard-wise into NBANK odd/even memory pairs, and any unwritten locations are zero-filled after the last frame.

## Interface
- DATA_W, 16: parallel input width; multiple of 8, at least 8.
- LEN_W, clog2(2*DATA_W/8): width of the length code.
- IMG_W, 16: image width in pixels; even.
- ROWS_PER_BANK, 4: image rows held by one odd/even bank pair.
- NBANK, 4: number of odd/even bank pairs.
- ADDR_W, clog2(ROWS_PER_BANK*IMG_W/2): bank address width.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- load, in, 1: load strobe; sampled only while ready=1.
- ready, out, 1: block is idle and accepts a load.
- pi_data, in, DATA_W: parallel data.
- pi_length, in, LEN_W: frame width F = 8*(pi_length+1); codes giving F > 2*DATA_W are clamped to 2*DATA_W.
- pi_fill, in, 1: for F > DATA_W, 1 places data at the top of the frame, 0 places it at the bottom.
- pi_msb, in, 1: 1 transmits frame bit F-1 first; 0 transmits bit 0 first.
- pi_low, in, 1: for F ≤ DATA_W, 1 selects the low F bits, 0 selects the high F bits.
- pi_end, in, 1: marks the accepted frame as the last one.
- so_data, out, 1: serial data.
- so_valid, out, 1: so_data is valid.
- oem_addr, out, ADDR_W: bank address.
- oem_dataout, out, 8: pixel data.
- odd_wr, out, NBANK: one-hot odd-bank write pulse.
- even_wr, out, NBANK: one-hot even-bank write pulse.
- oem_finish, out, 1: all TOTAL = IMG_W*ROWS_PER_BANK*NBANK pixels have been written.

## Operation
- **States**: IDLE, SHIFT, FILL, DONE.
  - ready=1 only in IDLE.
- **IDLE**
  - load=1 → capture the frame and the pi_end flag, clear the bit counter, go to SHIFT.
  - load while ready=0 is ignored; no queueing.
- **Frame construction**
  - F ≤ DATA_W: pi_low ? pi_data[F-1:0] : pi_data[DATA_W-1:DATA_W-F].
  - F > DATA_W: pi_fill ? {pi_data, (F-DATA_W)'b0} : {(F-DATA_W)'b0, pi_data}.
- **SHIFT**
  - Outputs one bit per cycle with so_valid=1, for exactly F cycles.
  - After the last bit: if the end flag is set, go to FILL (or DONE if the pixel counter has already reached TOTAL); otherwise go to IDLE.
- **Packing**
  - Serial bits shift into a byte in transmit order; the first bit becomes pixel bit 7.
  - Every 8th bit completes pixel p, where p is a counter running 0..TOTAL-1.
  - Frames are byte multiples, so no partial byte ever crosses a frame boundary.
- **Pixel mapping**
  - row = p / IMG_W, col = p % IMG_W.
  - bank = row / ROWS_PER_BANK.
  - (row+col) even → even_wr[bank]; odd → odd_wr[bank].
  - oem_addr = (row % ROWS_PER_BANK)*(IMG_W/2) + col/2.
- **Overflow**: once p = TOTAL, further completed bytes are discarded with no write pulses; serialisation continues normally.
- **FILL**
  - Writes 0x00 to pixels p..TOTAL-1, one per cycle, using the same mapping.
  - Then goes to DONE.
- **DONE**
  - oem_finish=1 and ready=0; both hold until reset.
  - load is ignored.
- **Reset** (async, active-low): every output goes to 0 immediately and all counters and state clear. The exception is ready, which is 1 once reset deasserts (IDLE).
  - Reset mid-operation abandons the frame; the next frame starts at pixel 0.

## Timing
- Load accepted at edge t → so_valid=1 during cycles t+1 … t+F; ready=0 from t+1 until the cycle after the last bit.
- Back-to-back frames have a minimum one-cycle so_valid gap (the IDLE cycle).
- Write pulse timing:
  - A write pulse occurs in the cycle after the 8th bit of its byte.
  - oem_addr and oem_dataout are valid in the pulse cycle and held until the next write.
  - At most one wr bit is high per cycle, and each pulse lasts one cycle.
- FILL starts the cycle after the final packed write; it issues one write per cycle with no gaps.
- oem_finish rises the cycle after the last fill write, or after the last data write if no fill is needed.

## Test plan
- **Low byte, MSB first**: DATA_W=16, pi_length=0, pi_low=1, pi_msb=1, pi_data=16'hA53C.
  - so_valid for 8 cycles, bits 0,0,1,1,1,1,0,0.
  - even_wr[0], addr 0, data 8'h3C.
- **32-bit frame, fill high, LSB first**: pi_length=3, pi_fill=1, pi_msb=0, pi_data=16'h8001.
  - 32 serial bits: 16 zeros, 1, 14 zeros, 1.
  - Writes: even0@0=00, odd0@0=00, even0@1=80, odd0@1=01.
- **Mapping at row 1**: 4 frames of 32 bits (16 pixels), then one 8-bit frame 0x5A.
  - Pixel 16 (row 1, col 0) → odd_wr[0], addr 8, data 5A.
- **Ignored load**: pulse load during SHIFT.
  - No extra so_valid cycles, no change to the current frame.
  - ready returns to 1 exactly one cycle after the last bit.
- **End and fill**: a single 8-bit frame with pi_end=1.
  - 255 zero writes follow in consecutive cycles.
  - Every bank address 0..31 is written exactly once.
  - oem_finish=1 and stays high.
- **Reset and overflow**:
  - Reset asserted mid-SHIFT → so_valid=0 immediately; after release, ready=1 and the next pixel is written to even0@0.
  - 65 frames of 32 bits → the 65th frame is serialised with no write pulses.
